ro_puf_ctrl: RTL
================

RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 Parameter N_BITS, default 4, number of response bits per challenge.
REQ-002 Parameter WINDOW, default 1024, count-window length in clk cycles.
REQ-003 Parameter SETTLE, default 8, oscillator settle length in clk cycles.
REQ-004 Parameter CNT_W, default 16, edge-counter width.
REQ-005 The clock SHALL be clk (input, 1 bit); the block SHALL use one clock domain.
REQ-006 The reset SHALL be rst_n (input, 1 bit), asynchronous and active-low.
REQ-007 start (input, 1): one-cycle request to evaluate challenge.
REQ-008 challenge (input, 6*N_BITS): field i = {idx_b[2:0], idx_a[2:0]}, sampled on accepted start.
REQ-009 mux_out_a, mux_out_b (input, 1 each): asynchronous oscillator outputs of the two 8:1 muxes.
REQ-010 ro_en (output, 1): enables all ring oscillators.
REQ-011 sel_a, sel_b (output, 4 each): mux selects, {1'b0, idx}.
REQ-012 busy (output, 1), done (output, 1, pulse), response (output, N_BITS), tie_mask (output, N_BITS).

Function
REQ-013 States SHALL be IDLE, SETTLE, COUNT, COMPARE, NEXT, DONE.
REQ-014 In IDLE, start=1 SHALL latch challenge, set pair index i=0, clear response/tie_mask, go to SETTLE; busy rises the next cycle.
REQ-015 start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-016 sel_a/sel_b SHALL drive field i throughout SETTLE, COUNT and COMPARE; in IDLE/DONE they hold their last values (0 after reset).
REQ-017 ro_en SHALL be 1 in SETTLE and COUNT only.
REQ-018 SETTLE SHALL last exactly SETTLE cycles; both counters are held at 0 during it.
REQ-019 mux_out_a/b SHALL each pass through a 2-flop synchronizer plus rising-edge detector; a detected edge increments its counter only in COUNT.
REQ-020 COUNT SHALL last exactly WINDOW cycles.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 COMPARE (1 cycle) SHALL set response[i] = (cnt_a > cnt_b) and tie_mask[i] = (cnt_a == cnt_b).
REQ-023 If idx_a == idx_b, the block SHALL skip SETTLE/COUNT for that pair and force response[i]=0, tie_mask[i]=1.
REQ-024 NEXT SHALL increment i; if i reaches N_BITS, go to DONE, else go to SETTLE.
REQ-025 DONE SHALL assert done for exactly one cycle, deassert busy, then return to IDLE.
REQ-026 response/tie_mask SHALL hold their final values until the next accepted start.
REQ-027 Latency from start to done for a challenge with no equal pairs SHALL be N_BITS*(SETTLE+WINDOW+2)+2 cycles, fixed.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and zero state, i, counters, synchronizers, ro_en, sel_a, sel_b, busy, done, response and tie_mask.
REQ-029 Reset during any busy state SHALL abort the evaluation with no done pulse; a fresh start is needed after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and default parameter constants.
REQ-031 One sub-module, ro_edge_counter (synchronizer, edge detect, saturating counter, clear, enable), SHALL be instantiated twice.

Verification
REQ-032 N_BITS=4, WINDOW=64, SETTLE=8; A toggles period 4 clk, B period 6; challenge 0x000C_88_D1 (fields A!=B) -> response 4'b1111, tie_mask 0, done at cycle 4*74+2.
REQ-033 Same with A period 6, B period 4 -> response 4'b0000, tie_mask 0.
REQ-034 Both inputs identical period 4 -> response 0, tie_mask 4'b1111.
REQ-035 A field with idx_a==idx_b=3 -> that bit response 0, tie 1; total latency shortened by SETTLE+WINDOW for that pair.
REQ-036 CNT_W=4, A toggles every clk cycle -> cnt_a stops at 15, never wraps; B quiet -> response bit 1.
REQ-037 Second start pulse mid-COUNT -> ignored; rst_n pulsed mid-COUNT -> all outputs 0, no done, next start runs a full evaluation.

Source files
------------

// File: rtl/ro_puf_ctrl_pkg.sv
// Shared FSM state encoding, default parameters and challenge-field helper
// for the ring-oscillator PUF controller.
package ro_puf_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_NEXT,
    S_DONE
  } state_e;

  localparam int unsigned DEF_N_BITS = 4;
  localparam int unsigned DEF_WINDOW = 1024;
  localparam int unsigned DEF_SETTLE = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  // Field layout is {idx_b[2:0], idx_a[2:0]}; identical indices compare an RO with itself.
  function automatic logic pair_equal(input logic [5:0] f);
    return f[5:3] == f[2:0];
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises an asynchronous oscillator output, detects rising edges and
// counts them with saturation; clear has priority over enable.
module ro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;

  assign rise  = sync2_q & ~prev_q;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (en_i && rise && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: for each challenge field, settles and counts
// two selected oscillators, then records which one ran faster (or a tie).
module ro_puf_ctrl
  import ro_puf_ctrl_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [6*N_BITS-1:0] challenge,
  input  logic                mux_out_a,
  input  logic                mux_out_b,
  output logic                ro_en,
  output logic [3:0]          sel_a,
  output logic [3:0]          sel_b,
  output logic                busy,
  output logic                done,
  output logic [N_BITS-1:0]   response,
  output logic [N_BITS-1:0]   tie_mask
);

  localparam int unsigned TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned IW   = $clog2(N_BITS + 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       i_q, i_d;
  logic [6*N_BITS-1:0] chal_q, chal_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [N_BITS-1:0]   resp_q, resp_d, tie_q, tie_d;
  logic [3:0]          sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]    cnt_a, cnt_b;
  logic [6*N_BITS-1:0] lk_src;
  logic [IW-1:0]       lk_idx;
  logic [5:0]          lk_field, cur_field;
  logic                enter;

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .async_i(mux_out_a),
    .clr_i(state_q == S_SETTLE), .en_i(state_q == S_COUNT), .cnt_o(cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .async_i(mux_out_b),
    .clr_i(state_q == S_SETTLE), .en_i(state_q == S_COUNT), .cnt_o(cnt_b)
  );

  // Look-ahead field selects the pair about to start so an equal-index pair
  // can jump straight to COMPARE without burning settle/count time.
  always_comb begin
    lk_src    = (state_q == S_IDLE) ? challenge : chal_q;
    lk_idx    = (state_q == S_IDLE) ? '0 : i_q + 1'b1;
    lk_field  = '0;
    cur_field = '0;
    for (int unsigned k = 0; k < N_BITS; k++) begin
      if (lk_idx == IW'(k)) lk_field  = lk_src[6*k +: 6];
      if (i_q == IW'(k))    cur_field = chal_q[6*k +: 6];
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    chal_d  = chal_q;
    tmr_d   = tmr_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    enter   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d = challenge;
          i_d    = '0;
          resp_d = '0;
          tie_d  = '0;
          busy_d = 1'b1;
          enter  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr_q == TW'(SETTLE - 1)) begin
          tmr_d   = '0;
          state_d = S_COUNT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (tmr_q == TW'(WINDOW - 1)) begin
          tmr_d   = '0;
          state_d = S_COMPARE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COMPARE: begin
        for (int unsigned k = 0; k < N_BITS; k++) begin
          if (i_q == IW'(k)) begin
            if (pair_equal(cur_field)) begin
              resp_d[k] = 1'b0;
              tie_d[k]  = 1'b1;
            end else begin
              resp_d[k] = (cnt_a > cnt_b);
              tie_d[k]  = (cnt_a == cnt_b);
            end
          end
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        i_d = lk_idx;
        if (lk_idx == IW'(N_BITS)) state_d = S_DONE;
        else                       enter   = 1'b1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter) begin
      tmr_d   = '0;
      sel_a_d = {1'b0, lk_field[2:0]};
      sel_b_d = {1'b0, lk_field[5:3]};
      state_d = pair_equal(lk_field) ? S_COMPARE : S_SETTLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      chal_q  <= '0;
      tmr_q   <= '0;
      resp_q  <= '0;
      tie_q   <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      chal_q  <= chal_d;
      tmr_q   <= tmr_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ro_en    = (state_q == S_SETTLE) || (state_q == S_COUNT);
  assign sel_a    = sel_a_q;
  assign sel_b    = sel_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = resp_q;
  assign tie_mask = tie_q;

endmodule
